// File: rtl/traffic_light_ctrl_if.sv
// Board-side bundle of the intersection controller: request inputs and lamp/debug outputs.
// The master drives the requests; the slave (controller) drives the lamps.
interface traffic_light_ctrl_if;
  logic       night;
  logic       ped_req;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       ped_walk;
  logic [3:0] state_o;

  modport master (
    output night,
    output ped_req,
    input  main_lights,
    input  side_lights,
    input  ped_walk,
    input  state_o
  );

  modport slave (
    input  night,
    input  ped_req,
    output main_lights,
    output side_lights,
    output ped_walk,
    output state_o
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with all-red clearance, latched pedestrian
// request that can shorten main green, and a blinking-amber night mode.
module traffic_light_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN     = 20,
  parameter int T_MIN_GREEN = 6,
  parameter int T_AMBER     = 4,
  parameter int T_RED_AMBER = 2,
  parameter int T_ALL_RED   = 2,
  parameter int T_BLINK     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  tl_if
);

  typedef enum logic [3:0] {
    ALLRED_A = 4'd0,
    MAIN_RA  = 4'd1,
    MAIN_GRE = 4'd2,
    MAIN_AMB = 4'd3,
    ALLRED_B = 4'd4,
    SIDE_RA  = 4'd5,
    SIDE_GRE = 4'd6,
    SIDE_AMB = 4'd7,
    NIGHT    = 4'd8
  } state_e;

  localparam logic [CNT_W-1:0] LAST_GREEN     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_MIN_GREEN = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_AMBER     = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] LAST_RA        = CNT_W'(T_RED_AMBER - 1);
  localparam logic [CNT_W-1:0] LAST_ALL_RED   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LAST_BLINK     = CNT_W'(T_BLINK - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  state_e           state_q, state_d, succ_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_s;
  logic             early_s;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic             blink_q, blink_d;
  logic [2:0]       main_q, main_d, side_q, side_d;

  // Phase table: duration and successor of the current state.
  always_comb begin
    last_s  = LAST_ALL_RED;
    succ_s  = ALLRED_A;
    early_s = 1'b0;
    case (state_q)
      ALLRED_A: begin last_s = LAST_ALL_RED; succ_s = tl_if.night ? NIGHT : MAIN_RA; end
      MAIN_RA:  begin last_s = LAST_RA;      succ_s = MAIN_GRE; end
      MAIN_GRE: begin
        last_s  = LAST_GREEN;
        succ_s  = MAIN_AMB;
        early_s = ped_pend_q && (cnt_q >= LAST_MIN_GREEN);
      end
      MAIN_AMB: begin last_s = LAST_AMBER;   succ_s = ALLRED_B; end
      ALLRED_B: begin last_s = LAST_ALL_RED; succ_s = tl_if.night ? NIGHT : SIDE_RA; end
      SIDE_RA:  begin last_s = LAST_RA;      succ_s = SIDE_GRE; end
      SIDE_GRE: begin last_s = LAST_GREEN;   succ_s = SIDE_AMB; end
      SIDE_AMB: begin last_s = LAST_AMBER;   succ_s = ALLRED_A; end
      NIGHT:    begin last_s = LAST_BLINK;   succ_s = ALLRED_A; end
      // Corrupted encodings fall back to the safe all-red state immediately.
      default:  begin last_s = CNT_ZERO;     succ_s = ALLRED_A; early_s = 1'b1; end
    endcase
  end

  // Next state, phase counter, blink phase, pedestrian latch and lamp pattern.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    blink_d = blink_q;
    if (state_q == NIGHT) begin
      if (!tl_if.night) begin
        state_d = ALLRED_A;
        cnt_d   = CNT_ZERO;
      end else if (cnt_q == LAST_BLINK) begin
        cnt_d   = CNT_ZERO;
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else if (early_s || (cnt_q == last_s)) begin
      state_d = succ_s;
      cnt_d   = CNT_ZERO;
      blink_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_ONE;
    end

    // The entry edge into side green is never inside side green, so a
    // coincident request always survives the clear.
    if (tl_if.ped_req) begin
      ped_pend_d = 1'b1;
    end else if ((state_d == SIDE_GRE) && (state_q != SIDE_GRE)) begin
      ped_pend_d = 1'b0;
    end else begin
      ped_pend_d = ped_pend_q;
    end

    if (state_d != SIDE_GRE) begin
      walk_d = 1'b0;
    end else if (state_q != SIDE_GRE) begin
      walk_d = ped_pend_q;
    end else begin
      walk_d = walk_q;
    end

    main_d = 3'b100;
    side_d = 3'b100;
    case (state_d)
      MAIN_RA:  main_d = 3'b110;
      MAIN_GRE: main_d = 3'b001;
      MAIN_AMB: main_d = 3'b010;
      SIDE_RA:  side_d = 3'b110;
      SIDE_GRE: side_d = 3'b001;
      SIDE_AMB: side_d = 3'b010;
      NIGHT: begin
        main_d = {1'b0, blink_d, 1'b0};
        side_d = {1'b0, blink_d, 1'b0};
      end
      default: begin
        main_d = 3'b100;
        side_d = 3'b100;
      end
    endcase
  end

  // State, counter and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALLRED_A;
      cnt_q      <= CNT_ZERO;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      blink_q    <= 1'b1;
      main_q     <= 3'b100;
      side_q     <= 3'b100;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      blink_q    <= blink_d;
      main_q     <= main_d;
      side_q     <= side_d;
    end
  end

  assign tl_if.main_lights = main_q;
  assign tl_if.side_lights = side_q;
  assign tl_if.ped_walk    = walk_q;
  assign tl_if.state_o     = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a table of phase rows expands into
// per-cycle expectations held in a scoreboard queue and compared at each falling edge.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RA = 3'b110;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] A  = 3'b010;
  localparam logic [2:0] O  = 3'b000;

  localparam logic [3:0] S_ARA = 4'd0, S_MRA = 4'd1, S_MG = 4'd2, S_MA = 4'd3;
  localparam logic [3:0] S_ARB = 4'd4, S_SRA = 4'd5, S_SG = 4'd6, S_SA = 4'd7;
  localparam logic [3:0] S_NT  = 4'd8;

  typedef struct {
    logic       night;
    logic       ped;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic [3:0] st;
    int         n;
  } vec_t;

  typedef struct {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic [3:0] st;
  } exp_t;

  logic clk;
  logic rst_n;
  traffic_light_ctrl_if tl ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tl_if (tl)
  );

  vec_t vecs[$];
  exp_t exp_q[$];
  int   passed;
  int   total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic nt, input logic pd, input logic [2:0] m,
                              input logic [2:0] s, input logic w, input logic [3:0] st,
                              input int n);
    vec_t v;
    v.night = nt; v.ped = pd; v.main = m; v.side = s; v.walk = w; v.st = st; v.n = n;
    vecs.push_back(v);
  endfunction

  function automatic void add_period();
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  20);
    add(1'b0, 1'b0, A,  R,  1'b0, S_MA,  4);
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARB, 2);
    add(1'b0, 1'b0, R,  RA, 1'b0, S_SRA, 2);
    add(1'b0, 1'b0, R,  G,  1'b0, S_SG,  20);
    add(1'b0, 1'b0, R,  A,  1'b0, S_SA,  4);
  endfunction

  function automatic void push_exp(input logic [2:0] m, input logic [2:0] s,
                                   input logic w, input logic [3:0] st);
    exp_t e;
    e.main = m; e.side = s; e.walk = w; e.st = st;
    exp_q.push_back(e);
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, nothing expected", name);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (tl.main_lights === e.main && tl.side_lights === e.side &&
          tl.ped_walk === e.walk && tl.state_o === e.st) begin
        passed++;
      end else begin
        $display("FAIL %s: got main=%b side=%b walk=%b st=%0d, want main=%b side=%b walk=%b st=%0d",
                 name, tl.main_lights, tl.side_lights, tl.ped_walk, tl.state_o,
                 e.main, e.side, e.walk, e.st);
      end
    end
  endtask

  // Inputs of a row take effect at the first rising edge inside it; ped is a one-edge pulse.
  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      tl.night   = vecs[r].night;
      tl.ped_req = vecs[r].ped;
      for (int c = 0; c < vecs[r].n; c++) begin
        push_exp(vecs[r].main, vecs[r].side, vecs[r].walk, vecs[r].st);
        @(negedge clk);
        check_out($sformatf("row%0d.cyc%0d", r, c));
        if (c == 0) tl.ped_req = 1'b0;
      end
    end
  endtask

  initial begin
    int split;
    passed = 0;
    total  = 0;

    // Two undisturbed periods of 56 cycles.
    add_period();
    add_period();
    // Early pedestrian request: 6 green cycles, walk for the whole side green.
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  1);
    add(1'b0, 1'b1, G,  R,  1'b0, S_MG,  5);
    add(1'b0, 1'b0, A,  R,  1'b0, S_MA,  4);
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARB, 2);
    add(1'b0, 1'b0, R,  RA, 1'b0, S_SRA, 2);
    add(1'b0, 1'b0, R,  G,  1'b1, S_SG,  20);
    add(1'b0, 1'b0, R,  A,  1'b0, S_SA,  4);
    // Late request after the minimum: amber right after 16 green cycles.
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  15);
    add(1'b0, 1'b1, G,  R,  1'b0, S_MG,  1);
    add(1'b0, 1'b0, A,  R,  1'b0, S_MA,  4);
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARB, 2);
    add(1'b0, 1'b0, R,  RA, 1'b0, S_SRA, 2);
    add(1'b0, 1'b0, R,  G,  1'b1, S_SG,  20);
    add(1'b0, 1'b0, R,  A,  1'b0, S_SA,  4);
    // Night raised mid main green: phase completes, then blinking amber.
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  10);
    add(1'b1, 1'b0, G,  R,  1'b0, S_MG,  10);
    add(1'b1, 1'b0, A,  R,  1'b0, S_MA,  4);
    add(1'b1, 1'b0, R,  R,  1'b0, S_ARB, 2);
    add(1'b1, 1'b0, A,  A,  1'b0, S_NT,  5);
    add(1'b1, 1'b0, O,  O,  1'b0, S_NT,  5);
    add(1'b1, 1'b0, A,  A,  1'b0, S_NT,  5);
    add(1'b1, 1'b0, O,  O,  1'b0, S_NT,  3);
    // Night dropped (with a request on the same edge): all-red next cycle.
    add(1'b0, 1'b1, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  6);
    add(1'b0, 1'b0, A,  R,  1'b0, S_MA,  4);
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARB, 2);
    add(1'b0, 1'b0, R,  RA, 1'b0, S_SRA, 2);
    add(1'b0, 1'b0, R,  G,  1'b1, S_SG,  3);
    add(1'b0, 1'b1, R,  G,  1'b1, S_SG,  5);
    split = vecs.size();
    // After the asynchronous reset the pending request must be gone: full green.
    add(1'b0, 1'b0, R,  R,  1'b0, S_ARA, 2);
    add(1'b0, 1'b0, RA, R,  1'b0, S_MRA, 2);
    add(1'b0, 1'b0, G,  R,  1'b0, S_MG,  20);
    add(1'b0, 1'b0, A,  R,  1'b0, S_MA,  1);

    rst_n      = 1'b0;
    tl.night   = 1'b0;
    tl.ped_req = 1'b0;
    push_exp(R, R, 1'b0, S_ARA);
    @(negedge clk);
    check_out("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_rows(0, split);

    // Asynchronous reset mid side green, checked before the next rising edge.
    #3 rst_n = 1'b0;
    #1;
    push_exp(R, R, 1'b0, S_ARA);
    check_out("async_reset_mid_side_green");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_rows(split, vecs.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
